add_share_arbiter: RTL and testbench
====================================

Name: add_share_arbiter

Overview:
- Shares one WIDTH-bit adder between two requester channels. Arbitration is round-robin.
- Each requester issues either a plain add (a+b) or an accumulate (own accumulator + a).
- The result leaves through a single-entry registered output with valid/ready backpressure, tagged with the requester id.
- Sits between the top-level pin decode (ui_in/uio_in operand capture) and uo_out. It is the sequencer for the design's adder datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- r0_valid  input  1  requester 0 has an operation pending.
- r0_ready  output  1  requester 0 operation accepted this cycle.
- r0_a  input  WIDTH  requester 0 operand a.
- r0_b  input  WIDTH  requester 0 operand b (ignored when r0_acc=1).
- r0_acc  input  1  1 = accumulate mode, 0 = plain add.
- r1_valid, r1_ready, r1_a, r1_b, r1_acc  same as requester 0, for requester 1.
- acc_clr  input  2  bit i clears accumulator i.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts result.
- res_sum  output  WIDTH  sum, low WIDTH bits.
- res_carry  output  1  carry out of the addition.
- res_id  output  1  requester that produced the result.
- acc0, acc1  output  WIDTH each  current accumulator values (for debug/readback).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0, acc0=acc1=0.
  - Round-robin pointer set so requester 0 wins the first contention.
  - Any held result is discarded. Reset overrides all other inputs that cycle.
- Readiness:
  - can_accept = !res_valid | res_ready. The output slot is empty or is being drained in the same cycle.
- Arbitration (combinational, evaluated every cycle):
  - Only one valid: it is granted.
  - Both valid: the requester not granted most recently wins.
  - The pointer updates only on an accepted transfer.
  - rX_ready = grantX & rX_valid & can_accept.
  - At most one ready is high per cycle. Ready may depend combinationally on valid.
- Requester rules:
  - Requesters must hold valid, a, b and acc stable until ready.
  - Deasserting valid before ready is legal; the request is simply withdrawn.
- Transfer and latency:
  - On a transfer in cycle t, res_valid=1 and res_sum/res_carry/res_id are valid from cycle t+1.
  - Latency is 1 cycle. Throughput is 1 op/cycle while res_ready=1.
- Plain add (acc=0):
  - {res_carry,res_sum} = a + b, computed at WIDTH+1 bits.
  - Accumulators are unchanged.
- Accumulate (acc=1):
  - {res_carry,res_sum} = accX + a.
  - accX <= (accX + a) mod 2^WIDTH, i.e. it wraps and the carry is reported only in res_carry.
  - b is ignored.
- Output hold:
  - When res_valid=1 and res_ready=0, all res_* outputs hold and no grant occurs.
  - When res_valid=1, res_ready=1 and no new transfer occurs, res_valid goes to 0 next cycle and res_sum/res_carry/res_id hold their last values.
- acc_clr:
  - acc_clr[i]=1 sets acc_i to 0 next cycle.
  - If it coincides with an accepted accumulate from requester i, the clear applies first: the op uses 0 as the old value, and acc_i becomes a.
  - Clearing the non-granted accumulator in the same cycle is independent.
- Fairness: under continuous contention with res_ready=1, grants alternate 0,1,0,1. Neither requester waits more than one transfer.

Test Plan:
- Reset, then r0 plain add a=0x7F, b=0x01, res_ready=1 -> r0_ready same cycle; next cycle res_valid=1, sum=0x80, carry=0, id=0.
- r0 and r1 both valid continuously, res_ready=1 -> grant order 0,1,0,1; r1 (a=0xFF, b=0x02) gives sum=0x01, carry=1, id=1.
- Backpressure: result held with res_ready=0 for 3 cycles while r1 valid -> r1_ready=0 and res_* stable. On res_ready=1, r1 is granted that same cycle; its result appears next cycle.
- Accumulate: r0 acc=1 with a=0x90, then a=0x90 -> sums 0x90 (carry 0) then 0x20 (carry 1); acc0=0x20; acc1 stays 0.
- acc_clr[0]=1 in the same cycle as an accepted r0 acc op with a=0x05 (acc0 previously 0x20) -> sum=0x05, acc0=0x05.
- rst_n=0 while res_valid=1 and res_ready=0 -> next cycle res_valid=0, acc0=acc1=0; the first contention after reset is granted to r0.

Source files
------------

// File: rtl/add_share_arbiter_if.sv
// Bundle of both requester channels, the result channel, and accumulator clear/readback.
// The arbiter sits on the slave side; requesters and the result consumer sit on the master side.
interface add_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic             r0_acc;

  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic             r1_acc;

  logic [1:0]       acc_clr;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_id;

  logic [WIDTH-1:0] acc0;
  logic [WIDTH-1:0] acc1;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_acc,
    input  r1_valid, r1_a, r1_b, r1_acc,
    input  acc_clr, res_ready,
    output r0_ready, r1_ready,
    output res_valid, res_sum, res_carry, res_id,
    output acc0, acc1
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_acc,
    output r1_valid, r1_a, r1_b, r1_acc,
    output acc_clr, res_ready,
    input  r0_ready, r1_ready,
    input  res_valid, res_sum, res_carry, res_id,
    input  acc0, acc1
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin sharing of one adder between two requesters; 1-cycle latency into a single
// registered result slot; a full slot that is not being drained blocks every grant.
module add_share_arbiter #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  add_share_arbiter_if.slave bus
);

  logic             res_valid_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_carry_q;
  logic             res_id_q;
  logic [WIDTH-1:0] acc0_q;
  logic [WIDTH-1:0] acc1_q;
  // Requester granted most recently; reset to 1 so requester 0 wins first contention.
  logic             last_q;

  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             xfer;
  logic             sel;
  logic             op_acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] old0;
  logic [WIDTH-1:0] old1;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum_full;

  always_comb begin
    can_accept = !res_valid_q || bus.res_ready;
    grant0     = bus.r0_valid && (!bus.r1_valid || last_q);
    grant1     = bus.r1_valid && (!bus.r0_valid || !last_q);
    sel        = grant1 && can_accept;
    xfer       = (grant0 || grant1) && can_accept;
  end

  assign bus.r0_ready = grant0 && can_accept;
  assign bus.r1_ready = grant1 && can_accept;

  // A clear coinciding with an accumulate takes effect before the add.
  always_comb begin
    old0     = bus.acc_clr[0] ? '0 : acc0_q;
    old1     = bus.acc_clr[1] ? '0 : acc1_q;
    op_a     = sel ? bus.r1_a   : bus.r0_a;
    op_b     = sel ? bus.r1_b   : bus.r0_b;
    op_acc   = sel ? bus.r1_acc : bus.r0_acc;
    addend   = op_acc ? (sel ? old1 : old0) : op_b;
    sum_full = {1'b0, op_a} + {1'b0, addend};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
      acc0_q      <= '0;
      acc1_q      <= '0;
      last_q      <= 1'b1;
    end else begin
      if (xfer) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= sum_full[WIDTH-1:0];
        res_carry_q <= sum_full[WIDTH];
        res_id_q    <= sel;
        last_q      <= sel;
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      acc0_q <= (xfer && !sel && op_acc) ? sum_full[WIDTH-1:0] : old0;
      acc1_q <= (xfer &&  sel && op_acc) ? sum_full[WIDTH-1:0] : old1;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_id    = res_id_q;
  assign bus.acc0      = acc0_q;
  assign bus.acc1      = acc1_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed scenarios with literal expectations, then randomized traffic, all shadowed
// by a transaction-level model compared against the DUT on every falling edge.
module tb_add_share_arbiter;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_share_arbiter_if #(.WIDTH(W)) bus();
  add_share_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: which requester is served, what it produces.
  bit   m_init = 1'b0;
  int   m_valid, m_sum, m_carry, m_id, m_last;
  int   m_acc [2];
  logic took0, took1;

  always @(negedge clk) begin
    int g, a, b, tot;
    bit acc, can;
    can = (m_valid == 0) || (bus.res_ready == 1'b1);
    g   = -1;
    if (bus.r0_valid && bus.r1_valid) g = (m_last == 0) ? 1 : 0;
    else if (bus.r0_valid)            g = 0;
    else if (bus.r1_valid)            g = 1;
    if (!can) g = -1;
    took0 = bus.r0_ready;
    took1 = bus.r1_ready;
    if (m_init) begin
      if (rst_n) begin
        chk("r0_ready", 32'(bus.r0_ready), 32'(g == 0));
        chk("r1_ready", 32'(bus.r1_ready), 32'(g == 1));
      end
      chk("res_valid", 32'(bus.res_valid), m_valid);
      chk("res_sum",   32'(bus.res_sum),   m_sum);
      chk("res_carry", 32'(bus.res_carry), m_carry);
      chk("res_id",    32'(bus.res_id),    m_id);
      chk("acc0",      32'(bus.acc0),      m_acc[0]);
      chk("acc1",      32'(bus.acc1),      m_acc[1]);
    end
    if (!rst_n) begin
      m_init = 1'b1;
      m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_last = 1;
      m_acc = '{0, 0};
    end else begin
      for (int i = 0; i < 2; i++) if (bus.acc_clr[i]) m_acc[i] = 0;
      if (g >= 0) begin
        a   = (g == 1) ? int'(bus.r1_a) : int'(bus.r0_a);
        b   = (g == 1) ? int'(bus.r1_b) : int'(bus.r0_b);
        acc = (g == 1) ? bus.r1_acc : bus.r0_acc;
        tot = a + (acc ? m_acc[g] : b);
        m_sum = tot & MASK; m_carry = tot >> W; m_id = g; m_valid = 1; m_last = g;
        if (acc) m_acc[g] = tot & MASK;
      end else if (bus.res_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    bus.acc_clr  = 2'b00;
  endtask

  task automatic set_r0(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc);
    bus.r0_valid = 1'b1; bus.r0_a = a; bus.r0_b = b; bus.r0_acc = acc;
  endtask

  task automatic set_r1(input logic [W-1:0] a, input logic [W-1:0] b, input logic acc);
    bus.r1_valid = 1'b1; bus.r1_a = a; bus.r1_b = b; bus.r1_acc = acc;
  endtask

  initial begin
    bus.r0_valid = 0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_acc = 0;
    bus.r1_valid = 0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_acc = 0;
    bus.acc_clr = 2'b00; bus.res_ready = 1'b1;
    rst_n = 1'b0;
    step(); step();
    chk("lit_rst_valid", 32'(bus.res_valid), 0);
    chk("lit_rst_acc0", 32'(bus.acc0), 0);
    rst_n = 1'b1;

    // Plain add from r0
    set_r0(8'h7F, 8'h01, 1'b0); #1;
    chk("lit_add_ready", 32'(bus.r0_ready), 1);
    step();
    chk("lit_add_valid", 32'(bus.res_valid), 1);
    chk("lit_add_sum", 32'(bus.res_sum), 32'h80);
    chk("lit_add_carry", 32'(bus.res_carry), 0);
    chk("lit_add_id", 32'(bus.res_id), 0);
    idle();

    // Contention: r0 was served last, so r1 goes first, then strict alternation
    set_r0(8'h01, 8'h01, 1'b0); set_r1(8'hFF, 8'h02, 1'b0); #1;
    chk("lit_cont_r1_first", 32'(bus.r1_ready), 1);
    chk("lit_cont_r0_wait", 32'(bus.r0_ready), 0);
    step();
    chk("lit_cont_sum1", 32'(bus.res_sum), 32'h01);
    chk("lit_cont_carry1", 32'(bus.res_carry), 1);
    chk("lit_cont_id1", 32'(bus.res_id), 1);
    chk("lit_cont_r0_next", 32'(bus.r0_ready), 1);
    step();
    chk("lit_cont_id2", 32'(bus.res_id), 0);
    chk("lit_cont_sum2", 32'(bus.res_sum), 32'h02);
    chk("lit_cont_r1_next", 32'(bus.r1_ready), 1);
    step();
    chk("lit_cont_id3", 32'(bus.res_id), 1);
    idle();
    step();

    // Backpressure: held result blocks r1 until the consumer drains
    bus.res_ready = 1'b0;
    set_r0(8'h03, 8'h04, 1'b0);
    step();
    bus.r0_valid = 1'b0;
    set_r1(8'hFF, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_bp_r1_blocked", 32'(bus.r1_ready), 0);
      chk("lit_bp_hold_sum", 32'(bus.res_sum), 32'h07);
      chk("lit_bp_hold_valid", 32'(bus.res_valid), 1);
      step();
    end
    bus.res_ready = 1'b1; #1;
    chk("lit_bp_r1_release", 32'(bus.r1_ready), 1);
    step();
    chk("lit_bp_id", 32'(bus.res_id), 1);
    chk("lit_bp_sum", 32'(bus.res_sum), 32'h01);
    idle();
    step();

    // Accumulate twice with wrap
    set_r0(8'h90, 8'h00, 1'b1);
    step();
    chk("lit_acc_sum1", 32'(bus.res_sum), 32'h90);
    chk("lit_acc_carry1", 32'(bus.res_carry), 0);
    step();
    chk("lit_acc_sum2", 32'(bus.res_sum), 32'h20);
    chk("lit_acc_carry2", 32'(bus.res_carry), 1);
    chk("lit_acc_acc0", 32'(bus.acc0), 32'h20);
    chk("lit_acc_acc1", 32'(bus.acc1), 0);
    idle();

    // Clear coinciding with accumulate
    bus.acc_clr = 2'b01;
    set_r0(8'h05, 8'h00, 1'b1);
    step();
    idle();
    chk("lit_clr_sum", 32'(bus.res_sum), 32'h05);
    chk("lit_clr_acc0", 32'(bus.acc0), 32'h05);

    // Reset while a result is held; r0 was last, yet r0 wins after reset
    set_r0(8'h10, 8'h20, 1'b0);
    step();
    bus.r0_valid = 1'b0; bus.res_ready = 1'b0;
    chk("lit_rh_sum", 32'(bus.res_sum), 32'h30);
    step();
    chk("lit_rh_valid", 32'(bus.res_valid), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("lit_rh_valid0", 32'(bus.res_valid), 0);
    chk("lit_rh_acc0", 32'(bus.acc0), 0);
    chk("lit_rh_acc1", 32'(bus.acc1), 0);
    bus.res_ready = 1'b1;
    set_r0(8'h01, 8'h02, 1'b0); set_r1(8'h03, 8'h04, 1'b0); #1;
    chk("lit_rh_r0_wins", 32'(bus.r0_ready), 1);
    chk("lit_rh_r1_waits", 32'(bus.r1_ready), 0);
    step();
    chk("lit_rh_id", 32'(bus.res_id), 0);
    idle();

    // Randomized traffic obeying the hold-until-ready rule
    for (int c = 0; c < 3000; c++) begin
      if (!bus.r0_valid || took0 || $urandom_range(0, 15) == 0) begin
        bus.r0_valid = ($urandom_range(0, 9) < 6);
        bus.r0_a = W'($urandom); bus.r0_b = W'($urandom); bus.r0_acc = 1'($urandom);
      end
      if (!bus.r1_valid || took1 || $urandom_range(0, 15) == 0) begin
        bus.r1_valid = ($urandom_range(0, 9) < 6);
        bus.r1_a = W'($urandom); bus.r1_b = W'($urandom); bus.r1_acc = 1'($urandom);
      end
      bus.acc_clr   = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
      bus.res_ready = ($urandom_range(0, 9) < 7);
      rst_n         = ($urandom_range(0, 299) != 0);
      step();
    end

    rst_n = 1'b1;
    idle();
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
